// File: rtl/weight_lane_loader_if.sv
// Bundle of the control, router-stream and PE-array handshake signals of
// weight_lane_loader. The loader is the slave; the controller/router side is the master.
interface weight_lane_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
);
  logic                          i_clear;
  logic                          i_load_start;
  logic [LEN_W-1:0]              i_kernel_len;
  logic [DATA_WIDTH-1:0]         i_data;
  logic                          i_data_valid;
  logic                          o_data_out_en;
  logic                          o_busy;
  logic [MAX_LEN*DATA_WIDTH-1:0] o_weights;
  logic                          o_weights_valid;
  logic                          i_weights_ready;
  logic                          o_overflow;

  modport master (
    output i_clear, i_load_start, i_kernel_len, i_data, i_data_valid, i_weights_ready,
    input  o_data_out_en, o_busy, o_weights, o_weights_valid, o_overflow
  );

  modport slave (
    input  i_clear, i_load_start, i_kernel_len, i_data, i_data_valid, i_weights_ready,
    output o_data_out_en, o_busy, o_weights, o_weights_valid, o_overflow
  );
endinterface

// File: rtl/weight_lane_loader.sv
// Assembles one kernel's serial weight bytes into a parallel lane vector.
// A fill bank collects the next kernel while a hold bank presents the current one.
module weight_lane_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  weight_lane_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t                        state, state_next;
  logic [LEN_W-1:0]              len;
  logic [LEN_W-1:0]              count;
  logic [MAX_LEN*DATA_WIDTH-1:0] fill_bank;
  logic [MAX_LEN*DATA_WIDTH-1:0] hold_bank;
  logic                          hold_valid;
  logic                          overflow;
  logic                          data_out_en;

  logic rst_any;
  logic hold_free;
  logic start_ok;
  logic start_bad;
  logic accept;
  logic transfer;

  assign rst_any   = i_rst || bus.i_clear;
  assign hold_free = !hold_valid || bus.i_weights_ready;

  always_ff @(posedge i_clk) begin
    if (rst_any) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_load_start) begin
          if (bus.i_kernel_len == '0 || bus.i_kernel_len > MAX_LEN_L) begin
            start_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (bus.i_data_valid) begin
          accept = 1'b1;
          if (count + LEN_W'(1) == len) state_next = PEND;
        end
      end
      PEND: begin
        if (hold_free) begin
          transfer   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst_any) begin
      len         <= '0;
      count       <= '0;
      fill_bank   <= '0;
      hold_bank   <= '0;
      hold_valid  <= 1'b0;
      overflow    <= 1'b0;
      data_out_en <= 1'b0;
    end else begin
      // Registered pop enable follows the next state so it drops on the last-byte edge.
      data_out_en <= (state_next == FILL);

      if (start_ok) begin
        len       <= bus.i_kernel_len;
        count     <= '0;
        fill_bank <= '0;
      end else if (accept) begin
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
          if (count == LEN_W'(k)) fill_bank[k*DATA_WIDTH +: DATA_WIDTH] <= bus.i_data;
        end
        count <= count + LEN_W'(1);
      end

      if (start_bad || (bus.i_data_valid && state != FILL)) overflow <= 1'b1;

      // A transfer into a hold bank being consumed this cycle keeps valid high.
      if (transfer) begin
        hold_bank  <= fill_bank;
        hold_valid <= 1'b1;
      end else if (hold_valid && bus.i_weights_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.o_data_out_en   = data_out_en;
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_weights       = hold_bank;
  assign bus.o_weights_valid = hold_valid;
  assign bus.o_overflow      = overflow;

endmodule

// File: tb/tb_weight_lane_loader.sv
// Self-checking bench for weight_lane_loader: directed scenarios plus a randomized
// stream of kernels scored against a queue of expected lane vectors.
module tb_weight_lane_loader;
  localparam int DW = 8;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int VW = ML * DW;
  localparam int NK = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  weight_lane_loader_if #(.DATA_WIDTH(DW), .MAX_LEN(ML), .LEN_W(LW)) bus ();

  weight_lane_loader #(.DATA_WIDTH(DW), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected lane vector: byte k of the kernel in lane k, unused lanes zero.
  function automatic logic [VW-1:0] model_vec(input logic [7:0] q[$]);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < q.size(); k++) v[k*DW +: DW] = q[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_clear      = 1'b0;
    bus.i_load_start = 1'b0;
    bus.i_kernel_len = '0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.i_weights_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_kernel(input int len);
    bus.i_kernel_len = LW'(len);
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_data       = b;
    bus.i_data_valid = 1'b1;
    tick();
    bus.i_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i_weights_ready = 1'b1;
    bus.i_load_start = 1'b1;
    bus.i_kernel_len = LW'(3);
    bus.i_data_valid = 1'b1;
    bus.i_data       = 8'hFF;
    rst = 1'b1;
    tick();
    checks++; if ({bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow}); end
    checks++; if (bus.o_weights !== '0) begin
      errors++; $display("FAIL reset_weights got=%h exp=0", bus.o_weights); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    do_reset();
    bus.i_weights_ready = 1'b1;
    start_kernel(9);
    checks++; if ({bus.o_data_out_en, bus.o_busy} !== 2'b11) begin
      errors++; $display("FAIL basic_fill_en got=%b exp=11", {bus.o_data_out_en, bus.o_busy}); end
    for (int i = 1; i <= 9; i++) begin
      q.push_back(8'(i));
      send_byte(8'(i));
    end
    checks++; if ({bus.o_weights_valid, bus.o_data_out_en, bus.o_busy} !== 3'b001) begin
      errors++; $display("FAIL basic_pend got=%b exp=001", {bus.o_weights_valid, bus.o_data_out_en, bus.o_busy}); end
    tick();
    checks++; if ({bus.o_weights_valid, bus.o_busy} !== 2'b10) begin
      errors++; $display("FAIL basic_valid got=%b exp=10", {bus.o_weights_valid, bus.o_busy}); end
    checks++; if (bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL basic_weights got=%h exp=%h", bus.o_weights, model_vec(q)); end
    tick();
    checks++; if ({bus.o_weights_valid, bus.o_busy, bus.o_overflow} !== 3'b000) begin
      errors++; $display("FAIL basic_consumed got=%b exp=000", {bus.o_weights_valid, bus.o_busy, bus.o_overflow}); end
    checks++; if (bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL basic_keep got=%h exp=%h", bus.o_weights, model_vec(q)); end
  endtask

  task automatic test_backpressure();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    do_reset();
    start_kernel(4);
    for (int i = 0; i < 4; i++) begin qa.push_back(8'hA0 + 8'(i)); send_byte(8'hA0 + 8'(i)); end
    tick();
    checks++; if (bus.o_weights_valid !== 1'b1 || bus.o_weights !== model_vec(qa)) begin
      errors++; $display("FAIL bp_a_valid got=%b/%h exp=1/%h", bus.o_weights_valid, bus.o_weights, model_vec(qa)); end
    start_kernel(4);
    for (int i = 0; i < 4; i++) begin qb.push_back(8'hB0 + 8'(i)); send_byte(8'hB0 + 8'(i)); end
    repeat (3) tick();
    checks++; if ({bus.o_weights_valid, bus.o_data_out_en, bus.o_busy} !== 3'b101) begin
      errors++; $display("FAIL bp_b_pend got=%b exp=101", {bus.o_weights_valid, bus.o_data_out_en, bus.o_busy}); end
    checks++; if (bus.o_weights !== model_vec(qa)) begin
      errors++; $display("FAIL bp_a_stable got=%h exp=%h", bus.o_weights, model_vec(qa)); end
    bus.i_weights_ready = 1'b1;
    tick();
    bus.i_weights_ready = 1'b0;
    checks++; if ({bus.o_weights_valid, bus.o_busy} !== 2'b10 || bus.o_weights !== model_vec(qb)) begin
      errors++; $display("FAIL bp_swap got=%b/%h exp=10/%h", {bus.o_weights_valid, bus.o_busy}, bus.o_weights, model_vec(qb)); end
    tick();
    bus.i_weights_ready = 1'b1;
    tick();
    bus.i_weights_ready = 1'b0;
    checks++; if (bus.o_weights_valid !== 1'b0 || bus.o_weights !== model_vec(qb)) begin
      errors++; $display("FAIL bp_b_consumed got=%b/%h exp=0/%h", bus.o_weights_valid, bus.o_weights, model_vec(qb)); end
  endtask

  task automatic test_gapped();
    logic [7:0] q[$];
    q = '{8'h11, 8'h22, 8'h33};
    do_reset();
    bus.i_weights_ready = 1'b1;
    start_kernel(3);
    send_byte(8'h11);
    tick();
    tick();
    checks++; if (bus.o_data_out_en !== 1'b1) begin
      errors++; $display("FAIL gap_en_hold1 got=%b exp=1", bus.o_data_out_en); end
    send_byte(8'h22);
    tick();
    checks++; if (bus.o_data_out_en !== 1'b1) begin
      errors++; $display("FAIL gap_en_hold2 got=%b exp=1", bus.o_data_out_en); end
    send_byte(8'h33);
    checks++; if (bus.o_data_out_en !== 1'b0) begin
      errors++; $display("FAIL gap_en_drop got=%b exp=0", bus.o_data_out_en); end
    tick();
    checks++; if (bus.o_weights_valid !== 1'b1 || bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL gap_weights got=%b/%h exp=1/%h", bus.o_weights_valid, bus.o_weights, model_vec(q)); end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    int bad[2];
    q = '{8'hAA, 8'hBB};
    bad = '{0, 17};
    do_reset();
    start_kernel(2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    checks++; if ({bus.o_weights_valid, bus.o_overflow} !== 2'b11 || bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL ovf_extra got=%b/%h exp=11/%h", {bus.o_weights_valid, bus.o_overflow}, bus.o_weights, model_vec(q)); end
    repeat (3) tick();
    checks++; if (bus.o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    checks++; if ({bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow} !== 4'b0000 || bus.o_weights !== '0) begin
      errors++; $display("FAIL ovf_clear got=%b/%h exp=0000/0", {bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow}, bus.o_weights); end
    for (int i = 0; i < 2; i++) begin
      start_kernel(bad[i]);
      checks++; if ({bus.o_overflow, bus.o_busy, bus.o_data_out_en} !== 3'b100) begin
        errors++; $display("FAIL ovf_badlen%0d got=%b exp=100", bad[i], {bus.o_overflow, bus.o_busy, bus.o_data_out_en}); end
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    q = '{8'h55, 8'h66};
    do_reset();
    start_kernel(9);
    for (int i = 0; i < 5; i++) send_byte(8'hE1 + 8'(i));
    rst = 1'b1;
    tick();
    checks++; if ({bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow} !== 4'b0000 || bus.o_weights !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%h exp=0000/0", {bus.o_busy, bus.o_weights_valid, bus.o_data_out_en, bus.o_overflow}, bus.o_weights); end
    rst = 1'b0;
    bus.i_weights_ready = 1'b1;
    start_kernel(2);
    send_byte(8'h55);
    send_byte(8'h66);
    tick();
    checks++; if (bus.o_weights_valid !== 1'b1 || bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL rstmid_newkernel got=%b/%h exp=1/%h", bus.o_weights_valid, bus.o_weights, model_vec(q)); end
  endtask

  task automatic test_ignored_start();
    logic [7:0] q[$];
    do_reset();
    bus.i_weights_ready = 1'b1;
    start_kernel(5);
    for (int i = 0; i < 5; i++) begin
      q.push_back(8'h70 + 8'(i));
      if (i == 2) begin
        bus.i_load_start = 1'b1;
        bus.i_kernel_len = LW'(2);
      end
      send_byte(8'h70 + 8'(i));
      bus.i_load_start = 1'b0;
      if (i == 3) begin
        checks++; if ({bus.o_data_out_en, bus.o_busy} !== 2'b11) begin
          errors++; $display("FAIL ign_still_fill got=%b exp=11", {bus.o_data_out_en, bus.o_busy}); end
      end
    end
    checks++; if (bus.o_data_out_en !== 1'b0) begin
      errors++; $display("FAIL ign_en_drop got=%b exp=0", bus.o_data_out_en); end
    tick();
    checks++; if ({bus.o_weights_valid, bus.o_overflow} !== 2'b10 || bus.o_weights !== model_vec(q)) begin
      errors++; $display("FAIL ign_weights got=%b/%h exp=10/%h", {bus.o_weights_valid, bus.o_overflow}, bus.o_weights, model_vec(q)); end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp_q[$];
    logic [7:0]    kq[$];
    logic [VW-1:0] exp_v;
    logic [VW-1:0] prev_w;
    logic [7:0]    b;
    logic          prev_hold;
    int            sent, consumed, len, idx, cyc;
    bit            sending;
    sent = 0; consumed = 0; len = 0; idx = 0; cyc = 0; sending = 0;
    prev_hold = 1'b0;
    prev_w = '0;
    do_reset();
    while (consumed < NK && cyc < 8000) begin
      bus.i_load_start = 1'b0;
      bus.i_data_valid = 1'b0;
      if (sending) begin
        checks++; if (bus.o_data_out_en !== 1'b1) begin
          errors++; $display("FAIL rnd_en cyc=%0d got=%b exp=1", cyc, bus.o_data_out_en); end
        if ($urandom_range(0, 3) != 0) begin
          b = 8'($urandom);
          bus.i_data = b;
          bus.i_data_valid = 1'b1;
          kq.push_back(b);
          idx++;
          if (idx == len) begin
            exp_q.push_back(model_vec(kq));
            sending = 0;
            sent++;
          end
        end
      end else if (sent < NK && !bus.o_busy) begin
        len = (sent == 0) ? ML : (sent == 1) ? 1 : $urandom_range(1, ML);
        bus.i_kernel_len = LW'(len);
        bus.i_load_start = 1'b1;
        kq.delete();
        idx = 0;
        sending = 1;
      end
      bus.i_weights_ready = 1'($urandom_range(0, 1));
      if (prev_hold) begin
        checks++; if (bus.o_weights_valid !== 1'b1 || bus.o_weights !== prev_w) begin
          errors++; $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", cyc, bus.o_weights_valid, bus.o_weights, prev_w); end
      end
      if (bus.o_weights_valid === 1'b1 && bus.i_weights_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected cyc=%0d got=%h exp=none", cyc, bus.o_weights);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.o_weights !== exp_v) begin
            errors++; $display("FAIL rnd_kernel%0d got=%h exp=%h", consumed, bus.o_weights, exp_v); end
        end
        consumed++;
      end
      prev_hold = bus.o_weights_valid && !bus.i_weights_ready;
      prev_w = bus.o_weights;
      tick();
      cyc++;
    end
    idle_inputs();
    checks++; if (consumed != NK) begin
      errors++; $display("FAIL rnd_timeout got=%0d kernels exp=%0d", consumed, NK); end
    checks++; if (bus.o_overflow !== 1'b0) begin
      errors++; $display("FAIL rnd_overflow got=%b exp=0", bus.o_overflow); end
  endtask

  initial begin
    idle_inputs();
    bus.i_weights_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_overflow();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
